alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: valid/ready request with opcode and
// operands, valid/ready result with carry and zero flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, opcode, in1, in2, out_ready,
        input  in_ready, out_valid, out, carry, zero
    );

    modport slave (
        input  in_valid, opcode, in1, in2, out_ready,
        output in_ready, out_valid, out, carry, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops; optional iterative mul/divu/remu under ALU_SEQ_MULDIV_EN.
// Latency: 1 cycle for ops 1..9 and undefined opcodes, WIDTH+1 cycles for A..C when ALU_SEQ_MULDIV_EN is defined.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [1:0] BUSY = 2'd1;
    localparam int         CW   = $clog2(WIDTH);
`endif

    logic [1:0]       state;
    logic [WIDTH-1:0] out_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH-1:0] res;
    logic             cy;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_ext;

    // Bit WIDTH of the widened left shift is exactly the last bit shifted out,
    // and falls to 0 once the shift amount exceeds WIDTH.
    always_comb begin
        res     = '0;
        cy      = 1'b0;
        sum     = {1'b0, bus.in1} + {1'b0, bus.in2};
        shl_ext = {1'b0, bus.in1} << bus.in2;
        case (bus.opcode)
            4'h1: begin res = sum[WIDTH-1:0]; cy = sum[WIDTH]; end
            4'h2: begin res = bus.in1 - bus.in2; cy = (bus.in1 < bus.in2); end
            4'h3: begin res = shl_ext[WIDTH-1:0]; cy = shl_ext[WIDTH]; end
            4'h4: res = bus.in1 >> bus.in2;
            4'h5: res = $signed(bus.in1) >>> bus.in2;
            4'h6: res = bus.in1 & bus.in2;
            4'h7: res = bus.in1 | bus.in2;
            4'h8: res = bus.in1 ^ bus.in2;
            4'h9: begin res = ~bus.in1; cy = 1'b1; end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] fin_out;
    logic             fin_cy;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   mac;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // acc_hi/acc_lo hold {product high, multiplier} for mul and
    // {partial remainder, dividend/quotient} for div. A zero divisor never
    // borrows, which naturally yields all-ones quotient and remainder = in1.
    always_comb begin
        mac     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (op_q == 4'hA) begin
            nxt_hi  = mac[WIDTH:1];
            nxt_lo  = {mac[0], acc_lo[WIDTH-1:1]};
            fin_out = nxt_lo;
            fin_cy  = |nxt_hi;
        end else begin
            nxt_hi  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo  = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
            fin_out = (op_q == 4'hC) ? nxt_hi : nxt_lo;
            fin_cy  = (b_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            op_q   <= bus.opcode;
            a_q    <= bus.in1;
            b_q    <= bus.in2;
            acc_hi <= '0;
            acc_lo <= (bus.opcode == 4'hA) ? bus.in2 : bus.in1;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (bus.opcode inside {4'hA, 4'hB, 4'hC}) begin
                        state <= BUSY;
                    end else
`endif
                    begin
                        state   <= DONE;
                        out_q   <= res;
                        carry_q <= cy;
                        zero_q  <= (res == '0);
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                // Final iteration retires straight into DONE from the next-state values.
                BUSY: if (cnt == CW'(WIDTH - 1)) begin
                    state   <= DONE;
                    out_q   <= fin_out;
                    carry_q <= fin_cy;
                    zero_q  <= (fin_out == '0);
                end
`endif
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=32; exercises the multi-cycle
// path only when ALU_SEQ_MULDIV_EN is defined.
module tb_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts negedges after the acceptance edge until out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) return;
        end
        lat = -1;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_out, input logic e_c,
                       input logic e_z, input int e_lat);
        int lat;
        @(posedge clk); #1;
        bus.opcode = op; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check($sformatf("%s.lat", tag), 64'(lat), 64'(e_lat));
        check($sformatf("%s.out", tag), 64'(bus.out), 64'(e_out));
        check($sformatf("%s.carry", tag), 64'(bus.carry), 64'(e_c));
        check($sformatf("%s.zero", tag), 64'(bus.zero), 64'(e_z));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.opcode = 4'h1;
        bus.in1 = 32'h1;
        bus.in2 = 32'h1;
        bus.out_ready = 1'b0;

        // Reset state, with in_valid asserted during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.out", 64'(bus.out), 64'd0);
        check("rst.carry", 64'(bus.carry), 64'd0);
        check("rst.zero", 64'(bus.zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst.no_accept", 64'(bus.out_valid), 64'd0);
        check("rst.idle", 64'(bus.in_ready), 64'd1);

        run("add_wrap", 4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1);
        run("add_small", 4'h1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1);
        run("sub_borrow", 4'h2, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        run("shl_1", 4'h3, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1, 1'b0, 1);
        run("shl_w", 4'h3, 32'h0000_0001, 32'd32, 32'h0000_0000, 1'b1, 1'b1, 1);
        run("shl_over", 4'h3, 32'hFFFF_FFFF, 32'd33, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("shr_4", 4'h4, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1);
        run("sar_4", 4'h5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 1);
        run("sar_40", 4'h5, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run("and", 4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1);
        run("or", 4'h7, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        run("xor_self", 4'h8, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("not_ones", 4'h9, 32'hFFFF_FFFF, 32'd0, 32'h0000_0000, 1'b1, 1'b1, 1);
        run("not_zero", 4'h9, 32'h0000_0000, 32'd7, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run("undef_0", 4'h0, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("undef_f", 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1);

`ifdef ALU_SEQ_MULDIV_EN
        run("mul_ovf", 4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 33);
        run("mul_small", 4'hA, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33);
        run("divu", 4'hB, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
        run("remu", 4'hC, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
        run("divu_z", 4'hB, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 33);
        run("remu_z", 4'hC, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 33);
`else
        run("mul_off", 4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
        run("div_off", 4'hB, 32'd100, 32'd7, 32'h0000_0000, 1'b0, 1'b1, 1);
`endif

        // Back-pressure: result held, new request ignored until after the out handshake.
        @(posedge clk); #1;
        bus.opcode = 4'h7; bus.in1 = 32'hF0F0_F0F0; bus.in2 = 32'h0F0F_0F0F; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.opcode = 4'h8; bus.in1 = 32'h1234_5678; bus.in2 = 32'h0000_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp.out%0d", i), 64'(bus.out), 64'hFFFF_FFFF);
            check($sformatf("bp.valid%0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp.in_ready%0d", i), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp.idle", 64'(bus.in_ready), 64'd1);
        check("bp.released", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp.next_valid", 64'(bus.out_valid), 64'd1);
        check("bp.next_out", 64'(bus.out), 64'h1234_A987);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset mid-operation abandons the result.
        @(posedge clk); #1;
`ifdef ALU_SEQ_MULDIV_EN
        bus.opcode = 4'hA; bus.in1 = 32'd9; bus.in2 = 32'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
`else
        bus.opcode = 4'h1; bus.in1 = 32'd5; bus.in2 = 32'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst.in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst.out", 64'(bus.out), 64'd0);
        check("mid_rst.zero", 64'(bus.zero), 64'd0);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mid_rst.no_result", 64'(seen), 64'd0);
        end

        run("post_rst_add", 4'h1, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
